// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues sequential word fetches to a 1-cycle imem,
// buffers returned words in a small FIFO, and flushes/restarts on redirect.
module fetch_queue #(
    parameter int unsigned                ADDRESS_WIDTH = 32,
    parameter int unsigned                DATA_WIDTH    = 32,
    parameter int unsigned                DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     instr_valid,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    input  logic                     instr_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0]    mem_data [DEPTH];
    logic [ADDRESS_WIDTH-1:0] mem_pc   [DEPTH];
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [CNT_W-1:0]         count;
    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic [ADDRESS_WIDTH-1:0] inflight_pc;
    logic                     inflight;
    logic                     inflight_epoch;
    logic                     epoch;
    logic                     run;

    logic [CNT_W:0]           used;
    logic                     issue;
    logic                     push;
    logic                     pop;

    // run holds off the first request until the first clock edge after reset release
    always_comb begin
        used        = {1'b0, count} + (CNT_W + 1)'(inflight);
        issue       = run && !redirect && (used < (CNT_W + 1)'(DEPTH));
        push        = inflight && (inflight_epoch == epoch) && !redirect;
        instr_valid = (count != '0) && !redirect;
        pop         = instr_valid && instr_ready;
        imem_req    = issue;
        imem_addr   = fetch_pc;
        instr       = mem_data[rd_ptr];
        instr_pc    = mem_pc[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run            <= 1'b0;
            fetch_pc       <= RESET_PC;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_pc    <= '0;
            epoch          <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else begin
            run <= 1'b1;
            if (redirect) begin
                fetch_pc <= redirect_pc & ~ADDRESS_WIDTH'(3);
                epoch    <= ~epoch;
                inflight <= 1'b0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                inflight       <= issue;
                inflight_epoch <= epoch;
                if (issue) begin
                    inflight_pc <= fetch_pc;
                    fetch_pc    <= fetch_pc + ADDRESS_WIDTH'(4);
                end
                if (push) begin
                    mem_data[wr_ptr] <= imem_rdata;
                    mem_pc[wr_ptr]   <= inflight_pc;
                    wr_ptr           <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && (count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue; imem model returns addr ^ 32'hA5A5_0000.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] imem_rdata = '0;
    logic [31:0] imem_rdata2 = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid, instr_valid2;
    logic [31:0] instr, instr2;
    logic [31:0] instr_pc, instr_pc2;
    logic        instr_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_rdata  <= imem_addr ^ KEY;
        imem_rdata2 <= imem_addr2 ^ KEY;
    end

    fetch_queue #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    fetch_queue #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .redirect(1'b0), .redirect_pc(32'h0),
        .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2),
        .instr_ready(1'b1)
    );

    // After this returns, the next negedge falls in the first cycle that issues
    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        instr_ready = ready;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({imem_req, instr_valid} !== 2'b00 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs req=%b valid=%b instr=%h pc=%h expected 0 0 0 0",
                     imem_req, instr_valid, instr, instr_pc);
        end
        do_reset(1'b1);
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                errors++;
                $display("FAIL stream_req cycle %0d got req=%b addr=%h expected 1 %h",
                         k, imem_req, imem_addr, 32'(4 * k));
            end
            checks++;
            if (k < 2) begin
                if (instr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_latency cycle %0d got valid=%b expected 0", k, instr_valid);
                end
            end else begin
                pc = 32'(4 * (k - 2));
                if (instr_valid !== 1'b1 || instr_pc !== pc || instr !== (pc ^ KEY)) begin
                    errors++;
                    $display("FAIL stream_out cycle %0d got valid=%b pc=%h instr=%h expected 1 %h %h",
                             k, instr_valid, instr_pc, instr, pc, pc ^ KEY);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc [5];
        logic        exp_req [3];
        exp_pc  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        exp_req = '{1'b0, 1'b1, 1'b1};
        do_reset(1'b0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); #1;
            checks++;
            if (imem_req !== (k < 4) || (k < 4 && imem_addr !== 32'(4 * k))) begin
                errors++;
                $display("FAIL stall_req cycle %0d got req=%b addr=%h expected %b %h",
                         k, imem_req, imem_addr, k < 4, 32'(4 * k));
            end
            if (k >= 2) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== KEY) begin
                    errors++;
                    $display("FAIL stall_hold cycle %0d got valid=%b pc=%h instr=%h expected 1 0 %h",
                             k, instr_valid, instr_pc, instr, KEY);
                end
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            instr_ready = 1'b1;
            #1;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc[k] || instr !== (exp_pc[k] ^ KEY)) begin
                errors++;
                $display("FAIL stall_drain %0d got valid=%b pc=%h expected 1 %h",
                         k, instr_valid, instr_pc, exp_pc[k]);
            end
            if (k < 3) begin
                checks++;
                if (imem_req !== exp_req[k] || (exp_req[k] && imem_addr !== 32'(16 + 4 * (k - 1)))) begin
                    errors++;
                    $display("FAIL stall_resume %0d got req=%b addr=%h expected %b %h",
                             k, imem_req, imem_addr, exp_req[k], 32'(16 + 4 * (k - 1)));
                end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redirect_cycle got valid=%b req=%b expected 0 0", instr_valid, imem_req);
        end
        @(negedge clk);
        redirect = 1'b0;
        instr_ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_restart got req=%b addr=%h valid=%b expected 1 100 0",
                     imem_req, imem_addr, instr_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h104) begin
            errors++;
            $display("FAIL redirect_gap got valid=%b addr=%h expected 0 104", instr_valid, imem_addr);
        end
        @(negedge clk); #1;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== (32'h100 ^ KEY)) begin
            errors++;
            $display("FAIL redirect_first got valid=%b pc=%h instr=%h expected 1 100 %h",
                     instr_valid, instr_pc, instr, 32'h100 ^ KEY);
        end
        @(negedge clk); #1;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h104) begin
            errors++;
            $display("FAIL redirect_second got valid=%b pc=%h expected 1 104", instr_valid, instr_pc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] targets [2];
        targets = '{32'h200, 32'h300};
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            redirect = 1'b1;
            redirect_pc = targets[k];
            #1;
            checks++;
            if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL b2b_redirect %0d got valid=%b req=%b expected 0 0", k, instr_valid, imem_req);
            end
        end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL b2b_restart got req=%b addr=%h expected 1 300", imem_req, imem_addr);
        end
        @(negedge clk); #1;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got valid=%b pc=%h expected 0", instr_valid, instr_pc);
        end
        @(negedge clk); #1;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h300) begin
            errors++;
            $display("FAIL b2b_first got valid=%b pc=%h expected 1 300", instr_valid, instr_pc);
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        do_reset(1'b1);
        @(negedge clk); #1;
        checks++;
        if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL wrap_first_req got req=%b addr=%h expected 1 fffffff8", imem_req2, imem_addr2);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            checks++;
            if (instr_valid2 !== 1'b1 || instr_pc2 !== exp_pc[k] || instr2 !== (exp_pc[k] ^ KEY)) begin
                errors++;
                $display("FAIL wrap_seq %0d got valid=%b pc=%h instr=%h expected 1 %h %h",
                         k, instr_valid2, instr_pc2, instr2, exp_pc[k], exp_pc[k] ^ KEY);
            end
        end
    endtask

    task automatic test_reset_midop();
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_req, instr_valid} !== 2'b00 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL midop_async got req=%b valid=%b instr=%h pc=%h expected 0 0 0 0",
                     imem_req, instr_valid, instr, instr_pc);
        end
        @(negedge clk);
        instr_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL midop_restart got req=%b addr=%h expected 1 0", imem_req, imem_addr);
        end
        @(negedge clk); #1;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL midop_stale got valid=%b pc=%h expected 0", instr_valid, instr_pc);
        end
        @(negedge clk); #1;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== KEY) begin
            errors++;
            $display("FAIL midop_first got valid=%b pc=%h instr=%h expected 1 0 %h",
                     instr_valid, instr_pc, instr, KEY);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_pc_wrap();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction fetch stage between the PC register and the decode/control logic that drives the ALU and register-file top.
- Issues sequential word fetches to instruction memory, which has a fixed 1-cycle read latency.
- Buffers returned instructions in a small FIFO and presents them to decode through a valid/ready handshake.
- A branch/jump redirect from the execute stage flushes the FIFO, discards in-flight data and restarts fetch at the target.

Parameters:
ADDRESS_WIDTH, 32, width of PC and instruction-memory address.
DATA_WIDTH, 32, instruction word width.
DEPTH, 4, FIFO entries. Must be a power of 2 and at least 2.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  asynchronous, active-low reset.
imem_req  out  1  fetch request this cycle.
imem_addr  out  ADDRESS_WIDTH  fetch address; valid when imem_req=1.
imem_rdata  in  DATA_WIDTH  instruction for the request issued in the previous cycle.
redirect  in  1  flush and restart fetch (taken branch/jump).
redirect_pc  in  ADDRESS_WIDTH  restart address; sampled when redirect=1.
instr_valid  out  1  FIFO head is valid.
instr  out  DATA_WIDTH  FIFO head instruction.
instr_pc  out  ADDRESS_WIDTH  address of instr.
instr_ready  in  1  decode accepts the head this cycle.

Behaviour:
Reset (rst=0, asynchronous):
- fetch_pc=RESET_PC; FIFO empty (count=0, pointers 0); inflight=0; epoch=0.
- imem_req=0, instr_valid=0, instr=0, instr_pc=0.
- Release is synchronous to clk. The first request (addr RESET_PC) is issued in the first cycle after rst rises.
- Reset mid-operation discards everything with no partial state.

Issue:
- imem_req = !redirect && (count + inflight < DEPTH).
- imem_addr = fetch_pc.
- On issue: fetch_pc += 4, wrapping modulo 2^ADDRESS_WIDTH. inflight (1 bit) is set for the next cycle, tagged with the current epoch.
- The issue decision ignores a pop in the same cycle (conservative credit). With DEPTH>=4 this still sustains 1 instruction/cycle.

Return:
- In the cycle after an issue, imem_rdata is pushed with its pc at the FIFO tail if the tag equals the current epoch and redirect=0. Otherwise it is dropped.
- Push is guaranteed never to overflow by the credit rule.
- Assert (simulation only): push while count==DEPTH is an error.

Output:
- instr_valid = (count!=0) && !redirect.
- instr and instr_pc show the head entry.
- Pop occurs when instr_valid && instr_ready. The head advances and the pointers wrap modulo DEPTH.
- Latency is 2 cycles: request in cycle t, push at end of t+1, instr_valid=1 in t+2.
- Push and pop in the same cycle leave count unchanged. With count==0, push then pop is not a bypass: the entry is visible the next cycle.

Redirect (highest priority):
- In the cycle redirect=1: no issue, no pop, no push.
- At the edge: FIFO cleared (count=0, rd=wr=0), epoch toggled, fetch_pc = {redirect_pc[ADDRESS_WIDTH-1:2],2'b00} (low bits forced to zero), inflight cleared.
- A response arriving in the cycle after the redirect carries the old epoch and is dropped. A response for a request issued in the redirect cycle cannot exist.
- Back-to-back redirects: the last one wins, and each flushes.
- Redirect together with reset: reset wins.

Stall:
- instr_ready=0 holds the head and instr_valid stable.
- Issue stops once count+inflight==DEPTH and resumes the cycle after a pop frees credit.

Test Plan:
- Reset release, instr_ready=1, imem returns word=addr^32'hA5A5_0000 -> imem_addr 0,4,8,... on consecutive cycles. First instr_valid 2 cycles after the first req with instr_pc=0, then one instruction per cycle in order.
- instr_ready=0 from the start -> exactly 4 requests (addr 0..0xC), then imem_req=0. count=4, head instr_pc=0 held stable. Raising instr_ready pops pc 0,4,8,C and fetch resumes at 0x10.
- Redirect to 32'h0000_0103 while 3 entries are queued and one request is in flight -> instr_valid=0 in the redirect cycle. The in-flight word is dropped, the next request is addr 0x100, and the first instr_pc after the flush is 0x100.
- Two redirects on consecutive cycles (0x200 then 0x300) -> no 0x200 fetch appears at the output. First output instr_pc=0x300.
- Start RESET_PC=32'hFFFF_FFF8, stream 4 instructions -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert rst low while the FIFO holds 2 entries and a request is in flight -> outputs go to 0 immediately (asynchronously). After release, fetch restarts at RESET_PC and no stale instruction appears.
